// File: rtl/alu_multicycle_if.sv
// Start/busy/done handshake bundle between the control unit and alu_multicycle.
interface alu_multicycle_if #(
    parameter int W     = 8,
    parameter int CMD_W = 4
);
    logic             start;
    logic [CMD_W-1:0] alu_cmd;
    logic [W-1:0]     inA;
    logic [W-1:0]     inB;
    logic             f_in;
    logic             busy;
    logic             done;
    logic [W-1:0]     rslt;
    logic [W-1:0]     rslt_hi;
    logic             out;

    modport master (
        output start, alu_cmd, inA, inB, f_in,
        input  busy, done, rslt, rslt_hi, out
    );

    modport slave (
        input  start, alu_cmd, inA, inB, f_in,
        output busy, done, rslt, rslt_hi, out
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle ops plus iterative shift (1 bit/cycle) and shift-add multiply.
module alu_multicycle #(
    parameter int W     = 8,
    parameter int CMD_W = 4
) (
    input logic             clk,
    input logic             reset,
    alu_multicycle_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(0);
    localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(1);
    localparam logic [CMD_W-1:0] OP_NOT  = CMD_W'(2);
    localparam logic [CMD_W-1:0] OP_CMP  = CMD_W'(3);
    localparam logic [CMD_W-1:0] OP_MOVL = CMD_W'(4);
    localparam logic [CMD_W-1:0] OP_MOVR = CMD_W'(5);
    localparam logic [CMD_W-1:0] OP_SHC  = CMD_W'(6);
    localparam logic [CMD_W-1:0] OP_ADC  = CMD_W'(7);
    localparam logic [CMD_W-1:0] OP_ADDI = CMD_W'(8);
    localparam logic [CMD_W-1:0] OP_SH   = CMD_W'(9);
    localparam logic [CMD_W-1:0] OP_MUL  = CMD_W'(10);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic          busy_q;
    logic          done_q;
    logic          out_q;
    logic [W-1:0]  rslt_q;
    logic [W-1:0]  hi_q;
    logic          is_mul;
    logic          left;
    logic [CW-1:0] cnt;
    logic [W-1:0]  work;
    logic [W-1:0]  acc;
    logic [W-1:0]  mcand;

    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W:0]    s_res;
    logic [W-1:0]  mag;
    logic [CW-1:0] k;
    logic [W:0]    sum;
    logic [W-1:0]  step_work;
    logic [W-1:0]  step_acc;
    logic          step_bit;

    assign a = bus.inA;
    assign b = bus.inB;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.out     = out_q;
    assign bus.rslt    = rslt_q;
    assign bus.rslt_hi = hi_q;

    always_comb begin
        s_res = '0;
        unique case (bus.alu_cmd)
            OP_ADD:  s_res = {1'b0, a} + {1'b0, b};
            OP_SUB:  s_res = {1'b0, a} - {1'b0, b};
            OP_NOT:  s_res = {1'b0, ~b};
            OP_CMP:  s_res = {a == b, {W{1'b0}}};
            OP_MOVL: s_res = {1'b0, b};
            OP_MOVR: s_res = {1'b0, a};
            OP_SHC:  s_res = b[3] ? {a[0], bus.f_in, a[W-1:1]}
                                  : {a[W-1], a[W-2:0], bus.f_in};
            OP_ADC:  s_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bus.f_in};
            // The immediate is already W bits wide; out is the carry of the W-bit add.
            OP_ADDI: s_res = {1'b0, a} + {1'b0, b};
            default: s_res = '0;
        endcase
    end

    // Most-negative immediate yields 2^(W-1) unsigned, which the clamp then caps at W.
    assign mag = b[W-1] ? -b : b;
    assign k   = (mag > W'(W)) ? CW'(W) : CW'(mag);

    always_comb begin
        sum       = '0;
        step_work = work;
        step_acc  = acc;
        step_bit  = 1'b0;
        if (is_mul) begin
            sum       = {1'b0, acc} + (work[0] ? {1'b0, mcand} : '0);
            step_acc  = sum[W:1];
            step_work = {sum[0], work[W-1:1]};
        end else if (left) begin
            step_work = {work[W-2:0], 1'b0};
            step_bit  = work[W-1];
        end else begin
            step_work = {1'b0, work[W-1:1]};
            step_bit  = work[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            out_q  <= 1'b0;
            rslt_q <= '0;
            hi_q   <= '0;
            is_mul <= 1'b0;
            left   <= 1'b0;
            cnt    <= '0;
            work   <= '0;
            acc    <= '0;
            mcand  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.alu_cmd == OP_MUL) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            is_mul <= 1'b1;
                            work   <= b;
                            mcand  <= a;
                            acc    <= '0;
                            cnt    <= CW'(W);
                        end else if (bus.alu_cmd == OP_SH && k != '0) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            is_mul <= 1'b0;
                            left   <= b[W-1];
                            work   <= a;
                            cnt    <= k;
                        end else if (bus.alu_cmd == OP_SH) begin
                            rslt_q <= a;
                            out_q  <= 1'b0;
                            hi_q   <= '0;
                            done_q <= 1'b1;
                        end else begin
                            rslt_q <= s_res[W-1:0];
                            out_q  <= s_res[W];
                            hi_q   <= '0;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    work <= step_work;
                    acc  <= step_acc;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        rslt_q <= step_work;
                        if (is_mul) begin
                            hi_q  <= step_acc;
                            out_q <= |step_acc;
                        end else begin
                            hi_q  <= '0;
                            out_q <= step_bit;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at W=8 and W=16.
module tb_alu_multicycle;
    logic clk;
    logic rst8;
    logic rst16;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        logic [15:0] r;
        logic [15:0] h;
        logic        o;
        int          at;
        string       nm;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    alu_multicycle_if #(.W(8),  .CMD_W(4)) bus8 ();
    alu_multicycle_if #(.W(16), .CMD_W(4)) bus16 ();

    alu_multicycle #(.W(8), .CMD_W(4)) dut8 (
        .clk   (clk),
        .reset (rst8),
        .bus   (bus8)
    );

    alu_multicycle #(.W(16), .CMD_W(4)) dut16 (
        .clk   (clk),
        .reset (rst16),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Call at a falling edge; drives start for exactly one accepting edge.
    task automatic issue(input bit wide, input bit push, input logic [3:0] cmd,
                         input logic [15:0] a, input logic [15:0] b, input logic f,
                         input logic [15:0] er, input logic [15:0] eh, input logic eo,
                         input int n, input string nm);
        int   guard;
        exp_t e;
        guard = 0;
        while ((wide ? bus16.busy : bus8.busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk({nm, "_wait_idle"}, 32'(guard), 32'd0);
        if (wide) begin
            bus16.start   = 1'b1;
            bus16.alu_cmd = cmd;
            bus16.inA     = a;
            bus16.inB     = b;
            bus16.f_in    = f;
        end else begin
            bus8.start   = 1'b1;
            bus8.alu_cmd = cmd;
            bus8.inA     = a[7:0];
            bus8.inB     = b[7:0];
            bus8.f_in    = f;
        end
        if (push) begin
            e.r  = er;
            e.h  = eh;
            e.o  = eo;
            e.at = cyc + 1 + n;
            e.nm = nm;
            if (wide) q16.push_back(e);
            else q8.push_back(e);
        end
        @(negedge clk);
        if (wide) bus16.start = 1'b0;
        else bus8.start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst8 && bus8.done) begin
            chk("busy_with_done8", 32'(bus8.busy), 32'd0);
            chk("pending8", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk({e.nm, "_rslt"}, 32'(bus8.rslt), 32'(e.r));
                chk({e.nm, "_hi"}, 32'(bus8.rslt_hi), 32'(e.h));
                chk({e.nm, "_out"}, 32'(bus8.out), 32'(e.o));
                chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst16 && bus16.done) begin
            chk("busy_with_done16", 32'(bus16.busy), 32'd0);
            chk("pending16", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk({e.nm, "_rslt"}, 32'(bus16.rslt), 32'(e.r));
                chk({e.nm, "_hi"}, 32'(bus16.rslt_hi), 32'(e.h));
                chk({e.nm, "_out"}, 32'(bus16.out), 32'(e.o));
                chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        int guard;
        n_cmp = 0;
        n_bad = 0;
        rst8  = 1'b1;
        rst16 = 1'b1;
        bus8.start = 1'b0; bus8.alu_cmd = '0; bus8.inA = '0; bus8.inB = '0; bus8.f_in = 1'b0;
        bus16.start = 1'b0; bus16.alu_cmd = '0; bus16.inA = '0; bus16.inB = '0; bus16.f_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_rslt", 32'(bus8.rslt), 32'd0);
        chk("rst_hi", 32'(bus8.rslt_hi), 32'd0);
        chk("rst_out", 32'(bus8.out), 32'd0);
        rst8  = 1'b0;
        rst16 = 1'b0;
        @(negedge clk);

        issue(0, 1, 4'h0, 16'hF0, 16'h20, 0, 16'h10, 16'h0, 1, 0, "add");
        issue(0, 1, 4'hA, 16'hFF, 16'hFF, 0, 16'h01, 16'hFE, 1, 8, "mul_ff");
        chk("mul_busy", 32'(bus8.busy), 32'd1);
        chk("mul_hold_rslt", 32'(bus8.rslt), 32'h10);
        issue(0, 1, 4'h9, 16'h81, 16'hFD, 0, 16'h08, 16'h0, 0, 3, "shl3");
        issue(0, 1, 4'h9, 16'h80, 16'h09, 0, 16'h00, 16'h0, 1, 8, "shr_clamp");
        issue(0, 1, 4'h9, 16'h5A, 16'h00, 0, 16'h5A, 16'h0, 0, 0, "sh0");
        issue(0, 1, 4'h1, 16'h05, 16'h07, 0, 16'hFE, 16'h0, 1, 0, "sub_borrow");
        issue(0, 1, 4'h2, 16'h33, 16'h0F, 0, 16'hF0, 16'h0, 0, 0, "not");
        issue(0, 1, 4'h3, 16'h33, 16'h33, 0, 16'h00, 16'h0, 1, 0, "cmp_eq");
        issue(0, 1, 4'h3, 16'h33, 16'h34, 0, 16'h00, 16'h0, 0, 0, "cmp_ne");
        issue(0, 1, 4'h4, 16'h11, 16'h22, 0, 16'h22, 16'h0, 0, 0, "movl");
        issue(0, 1, 4'h5, 16'h11, 16'h22, 0, 16'h11, 16'h0, 0, 0, "movr");
        issue(0, 1, 4'h6, 16'h03, 16'h08, 1, 16'h81, 16'h0, 1, 0, "shc_r");
        issue(0, 1, 4'h6, 16'h81, 16'h00, 0, 16'h02, 16'h0, 1, 0, "shc_l");
        issue(0, 1, 4'h7, 16'hFF, 16'h00, 1, 16'h00, 16'h0, 1, 0, "adc");
        issue(0, 1, 4'h8, 16'h05, 16'hFF, 0, 16'h04, 16'h0, 1, 0, "addi");
        issue(0, 1, 4'h9, 16'h01, 16'h80, 0, 16'h00, 16'h0, 1, 8, "sh_minneg");
        issue(0, 1, 4'hC, 16'h5A, 16'hA5, 1, 16'h00, 16'h0, 0, 0, "nop");

        // A start landing at E3 of a multiply must be dropped.
        issue(0, 1, 4'hA, 16'h12, 16'h34, 0, 16'hA8, 16'h03, 1, 8, "mul_ign");
        repeat (2) @(negedge clk);
        bus8.start = 1'b1; bus8.alu_cmd = 4'h0; bus8.inA = 8'h01; bus8.inB = 8'h01;
        @(negedge clk);
        bus8.start = 1'b0;

        // Abort a multiply with reset just after its E4.
        issue(0, 0, 4'hA, 16'h07, 16'h09, 0, 16'h0, 16'h0, 0, 8, "mul_abort");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst8 = 1'b1;
        #1;
        chk("abort_busy", 32'(bus8.busy), 32'd0);
        chk("abort_done", 32'(bus8.done), 32'd0);
        chk("abort_rslt", 32'(bus8.rslt), 32'd0);
        chk("abort_hi", 32'(bus8.rslt_hi), 32'd0);
        chk("abort_out", 32'(bus8.out), 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        issue(0, 1, 4'h0, 16'h01, 16'h02, 0, 16'h03, 16'h0, 0, 0, "add_after_rst");

        issue(1, 1, 4'hA, 16'hFFFF, 16'h0002, 0, 16'hFFFE, 16'h0001, 1, 16, "mul16");
        issue(1, 1, 4'h8, 16'h0005, 16'hFFFF, 0, 16'h0004, 16'h0000, 1, 0, "addi16");

        guard = 0;
        while ((q8.size() + q16.size()) != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(q8.size() + q16.size()), 32'd0);
        repeat (12) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
